// File: rtl/control_seq_if.sv
// control_seq_if: instruction fields, memory handshake and datapath control bus of the sequencer
// Ports (master = sequencer side):
//   in : opcode, funct3, bit20, bit30, cmp_out, mem_ready
//   out: pc_enable, pc_load, reg_re1, reg_re2, reg_we, alu_sel1, alu_sel2, target_load,
//        mem_addr_sel, inst_load, inst_mux_sel, alu_op, wd_sel, mem_read_op, mem_write_op,
//        halt, fault, state, cycle_count, instret_count
interface control_seq_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             bit20, bit30, cmp_out, mem_ready;
    logic             pc_enable, pc_load, reg_re1, reg_re2, reg_we, alu_sel1, alu_sel2;
    logic             target_load, mem_addr_sel, inst_load, inst_mux_sel;
    logic [4:0]       alu_op;
    logic [1:0]       wd_sel;
    logic [2:0]       mem_read_op;
    logic [1:0]       mem_write_op;
    logic             halt, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count, instret_count;
    modport master (
        input  opcode, funct3, bit20, bit30, cmp_out, mem_ready,
        output pc_enable, pc_load, reg_re1, reg_re2, reg_we, alu_sel1, alu_sel2, target_load,
               mem_addr_sel, inst_load, inst_mux_sel, alu_op, wd_sel, mem_read_op, mem_write_op,
               halt, fault, state, cycle_count, instret_count
    );
    modport slave (
        output opcode, funct3, bit20, bit30, cmp_out, mem_ready,
        input  pc_enable, pc_load, reg_re1, reg_re2, reg_we, alu_sel1, alu_sel2, target_load,
               mem_addr_sel, inst_load, inst_mux_sel, alu_op, wd_sel, mem_read_op, mem_write_op,
               halt, fault, state, cycle_count, instret_count
    );
endinterface

// File: rtl/control_seq.sv
// control_seq: multicycle RV32I control sequencer with ready-based memory handshake
// Ports: clk, reset_n (async active-low), bus (control_seq_if.master: instruction fields,
//        mem_ready, datapath controls, halt/fault/state, cycle and retired counters)
// Optional: CONTROL_TIMEOUT_EN enables the memory-wait timeout into the sticky FAULT state.
module control_seq #(
    parameter int CNT_W    = 32,
    parameter int SKIP_MEM = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    control_seq_if.master bus
);
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_JALR = 7'b1100111,
                           OP_JAL = 7'b1101111, OP_BRANCH = 7'b1100011, OP_OPIMM = 7'b0010011,
                           OP_OP = 7'b0110011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] LW = 3'b010, LNONE = 3'b111;
    localparam logic [1:0] SNONE = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEM = 3'd2, S_EXEC = 3'd3, S_HALTED = 3'd4, S_FAULT = 3'd5
    } state_t;

    state_t           r_state, w_next;
    logic             r_halt, r_fault;
    logic [CNT_W-1:0] r_cycle, r_instret;

    logic w_ld, w_st, w_jalr, w_jal, w_br, w_opi, w_op, w_lui, w_auipc, w_ldst, w_memop, w_stop;
    logic w_wait, w_tmo;

    assign w_ld    = bus.opcode == OP_LOAD;
    assign w_st    = bus.opcode == OP_STORE;
    assign w_jalr  = bus.opcode == OP_JALR;
    assign w_jal   = bus.opcode == OP_JAL;
    assign w_br    = bus.opcode == OP_BRANCH;
    assign w_opi   = bus.opcode == OP_OPIMM;
    assign w_op    = bus.opcode == OP_OP;
    assign w_lui   = bus.opcode == OP_LUI;
    assign w_auipc = bus.opcode == OP_AUIPC;
    assign w_ldst  = w_ld | w_st;
    assign w_memop = w_ldst | w_jalr;
    assign w_stop  = (bus.opcode == OP_SYSTEM) & bus.bit20;
    // cycles in which the sequencer is stalled on the memory handshake
    assign w_wait  = (r_state == S_FETCH) | ((r_state == S_MEM) & w_ldst);

`ifdef CONTROL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] r_wait;
    assign w_tmo = w_wait & ~bus.mem_ready & (r_wait == WW'(TIMEOUT - 1));
    // counts consecutive not-ready cycles; any non-waiting cycle (including every entry) clears it
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_wait <= '0;
        else          r_wait <= (w_wait && !bus.mem_ready) ? r_wait + 1'b1 : '0;
    assign bus.fault = r_fault;
`else
    assign w_tmo     = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (w_memop || SKIP_MEM == 0) ? S_MEM : S_EXEC;
            S_MEM:    w_next = (!w_ldst || bus.mem_ready) ? S_EXEC : S_MEM;
            S_EXEC:   w_next = w_stop ? S_HALTED : S_FETCH;
            default:  w_next = r_state;
        endcase
        if (w_tmo) w_next = S_FAULT;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_halt    <= 1'b0;
            r_fault   <= 1'b0;
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_halt  <= w_next == S_HALTED;
            r_fault <= w_next == S_FAULT;
            if (r_state != S_HALTED && r_state != S_FAULT) r_cycle <= r_cycle + 1'b1;
            if (r_state == S_EXEC && !w_stop) r_instret <= r_instret + 1'b1;
        end

    always_comb begin
        bus.pc_enable    = 1'b0;
        bus.pc_load      = 1'b0;
        bus.reg_re1      = 1'b0;
        bus.reg_re2      = 1'b0;
        bus.reg_we       = 1'b0;
        bus.alu_sel1     = 1'b0;
        bus.alu_sel2     = 1'b0;
        bus.target_load  = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.inst_load    = 1'b0;
        bus.inst_mux_sel = (r_state == S_MEM) || (r_state == S_EXEC);
        bus.alu_op       = '0;
        bus.wd_sel       = (w_jal || w_jalr) ? 2'b01 : w_ld ? 2'b11 : 2'b00;
        bus.mem_read_op  = LNONE;
        bus.mem_write_op = SNONE;
        case (r_state)
            S_FETCH: bus.mem_read_op = LW;
            S_DECODE: begin
                bus.reg_re1     = 1'b1;
                bus.reg_re2     = 1'b1;
                bus.inst_load   = 1'b1;
                bus.target_load = 1'b1;
                bus.alu_sel1    = 1'b1;
                bus.alu_sel2    = 1'b1;
            end
            S_MEM: begin
                bus.mem_addr_sel = 1'b1;
                bus.target_load  = w_jalr;
                bus.alu_sel2     = w_memop;
                bus.mem_read_op  = w_ld ? bus.funct3 : LNONE;
                bus.mem_write_op = w_st ? bus.funct3[1:0] : SNONE;
            end
            S_EXEC: begin
                bus.pc_enable = !w_stop;
                bus.pc_load   = (w_br & bus.cmp_out) | w_jal | w_jalr;
                bus.reg_we    = w_opi | w_lui | w_op | w_auipc | w_jal | w_jalr | w_ld;
                bus.alu_sel1  = w_auipc;
                bus.alu_sel2  = w_auipc | w_opi | w_lui;
                // bit30 selects SUB/SRA for OP and only SRAI among the immediates
                bus.alu_op    = (w_op || (w_opi && bus.funct3 == 3'b101)) ? {1'b0, bus.bit30, bus.funct3} :
                                w_opi ? {2'b00, bus.funct3} : w_br ? {2'b10, bus.funct3} : 5'd0;
            end
            default: ;
        endcase
    end

    assign bus.halt          = r_halt;
    assign bus.state         = r_state;
    assign bus.cycle_count   = r_cycle;
    assign bus.instret_count = r_instret;
endmodule
